// File: rtl/gb_cpu_common_pkg.sv
// Shared GB CPU constants: interrupt sources, vectors,
// register addresses and the IME state encoding.
package gb_cpu_common_pkg;

  typedef enum logic [2:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT   = 3'd1,
    IRQ_TIMER  = 3'd2,
    IRQ_SERIAL = 3'd3,
    IRQ_JOYPAD = 3'd4
  } irq_src_t;

  typedef enum logic [1:0] {
    IME_OFF    = 2'd0,
    IME_ARMING = 2'd1,
    IME_ON     = 2'd2
  } ime_state_t;

  localparam int NUM_IRQ = 5;

  localparam logic [15:0] IRQ_VEC_BASE = 16'h0040;
  localparam logic [15:0] ADDR_IF      = 16'hFF0F;
  localparam logic [15:0] ADDR_IE      = 16'hFFFF;

  localparam logic [2:0] ISR_M_ENTRY   = 3'd0;
  localparam logic [2:0] ISR_M_RESOLVE = 3'd3;

  function automatic logic [15:0] irq_vector(
    input logic [2:0] idx
  );
    return IRQ_VEC_BASE + {10'd0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/gb_cpu_irq_prio_enc.sv
// Fixed-priority encoder for pending interrupts,
// bit 0 (VBlank) wins.
module gb_cpu_irq_prio_enc
  import gb_cpu_common_pkg::*;
(
  input  logic [4:0] req_i,
  output logic [2:0] index_o,
  output logic       any_o
);

  always_comb begin
    index_o = '0;
    any_o   = |req_i;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) index_o = 3'(i);
    end
  end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// IE/IF registers, IME with EI delay, and ISR
// vector resolution for the GB CPU scheduler.
module gb_cpu_interrupt_ctrl
  import gb_cpu_common_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  irq_req_i,
  input  logic        ei_i,
  input  logic        di_i,
  input  logic        reti_i,
  input  logic        instr_boundary_i,
  input  logic        isr_cmd_i,
  input  logic [2:0]  isr_m_cycle_i,
  input  logic [15:0] addr_i,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        interrupt_queued_o,
  output logic        halt_wake_o,
  output logic [15:0] isr_vector_o
);

  logic [7:0]  ie_q, ie_d;
  logic [4:0]  if_q, if_d;
  ime_state_t  state_q, state_d;
  logic        seen_q, seen_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [15:0] vec_q, vec_d;

  logic [4:0] pend;
  logic [4:0] clr_mask;
  logic [2:0] prio_idx;
  logic       prio_any;
  logic       isr_entry, isr_resolve;
  logic       wr_if, wr_ie, rd_if, rd_ie;

  assign pend        = ie_q[4:0] & if_q;
  assign isr_entry   = isr_cmd_i &&
                       (isr_m_cycle_i == ISR_M_ENTRY);
  assign isr_resolve = isr_cmd_i &&
                       (isr_m_cycle_i == ISR_M_RESOLVE);
  assign wr_if = wr_en_i && (addr_i == ADDR_IF);
  assign wr_ie = wr_en_i && (addr_i == ADDR_IE);
  assign rd_if = rd_en_i && (addr_i == ADDR_IF);
  assign rd_ie = rd_en_i && (addr_i == ADDR_IE);

  gb_cpu_irq_prio_enc u_prio (
    .req_i   (pend),
    .index_o (prio_idx),
    .any_o   (prio_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q    <= '0;
      if_q    <= '0;
      state_q <= IME_OFF;
      seen_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      vec_q   <= '0;
    end else begin
      ie_q    <= ie_d;
      if_q    <= if_d;
      state_q <= state_d;
      seen_q  <= seen_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      vec_q   <= vec_d;
    end
  end

  // Peripheral requests are OR'd last so they beat writes and acks.
  always_comb begin
    clr_mask = '0;
    vec_d    = vec_q;
    if (isr_resolve) begin
      if (prio_any) begin
        clr_mask = 5'(1) << prio_idx;
        vec_d    = irq_vector(prio_idx);
      end else begin
        vec_d    = 16'h0000;
      end
    end
    if_d = wr_if ? data_i[4:0] : (if_q & ~clr_mask);
    if_d = if_d | irq_req_i;
    ie_d = wr_ie ? data_i : ie_q;
  end

  always_comb begin
    valid_d = rd_if | rd_ie;
    data_d  = data_q;
    if (rd_if)      data_d = {3'b111, if_q};
    else if (rd_ie) data_d = ie_q;
  end

  // seen_q marks EI's own boundary; the next one enables IME.
  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    if (isr_entry || di_i) begin
      state_d = IME_OFF;
      seen_d  = 1'b0;
    end else if (reti_i) begin
      state_d = IME_ON;
      seen_d  = 1'b0;
    end else begin
      unique case (state_q)
        IME_OFF: begin
          seen_d = 1'b0;
          if (ei_i) state_d = IME_ARMING;
        end
        IME_ARMING: begin
          if (instr_boundary_i) begin
            if (seen_q) begin
              state_d = IME_ON;
              seen_d  = 1'b0;
            end else begin
              seen_d  = 1'b1;
            end
          end
        end
        IME_ON: state_d = IME_ON;
        default: begin
          state_d = IME_OFF;
          seen_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    interrupt_queued_o = (state_q == IME_ON) && (|pend) &&
                         !isr_entry;
    halt_wake_o        = |pend;
    data_o             = data_q;
    data_valid_o       = valid_q;
    isr_vector_o       = vec_q;
  end

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Self-checking bench: directed scenarios plus a
// randomized run against an abstract IE/IF/IME model.
module tb_gb_cpu_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  irq_req_i;
  logic        ei_i, di_i, reti_i, instr_boundary_i;
  logic        isr_cmd_i;
  logic [2:0]  isr_m_cycle_i;
  logic [15:0] addr_i;
  logic        wr_en_i, rd_en_i;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        interrupt_queued_o;
  logic        halt_wake_o;
  logic [15:0] isr_vector_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gb_cpu_interrupt_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .irq_req_i          (irq_req_i),
    .ei_i               (ei_i),
    .di_i               (di_i),
    .reti_i             (reti_i),
    .instr_boundary_i   (instr_boundary_i),
    .isr_cmd_i          (isr_cmd_i),
    .isr_m_cycle_i      (isr_m_cycle_i),
    .addr_i             (addr_i),
    .wr_en_i            (wr_en_i),
    .rd_en_i            (rd_en_i),
    .data_i             (data_i),
    .data_o             (data_o),
    .data_valid_o       (data_valid_o),
    .interrupt_queued_o (interrupt_queued_o),
    .halt_wake_o        (halt_wake_o),
    .isr_vector_o       (isr_vector_o)
  );

  task automatic idle();
    irq_req_i = '0; ei_i = 0; di_i = 0; reti_i = 0;
    instr_boundary_i = 0; isr_cmd_i = 0;
    isr_m_cycle_i = '0; addr_i = '0; wr_en_i = 0;
    rd_en_i = 0; data_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
    step();
  endtask

  task automatic do_wr(input logic [15:0] a,
                       input logic [7:0] d);
    addr_i = a; data_i = d; wr_en_i = 1;
    step();
    wr_en_i = 0;
  endtask

  task automatic do_rd(input logic [15:0] a);
    addr_i = a; rd_en_i = 1;
    step();
    rd_en_i = 0;
  endtask

  task automatic isr_cyc(input int m);
    isr_cmd_i = 1; isr_m_cycle_i = 3'(m);
    step();
    isr_cmd_i = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle();
    do_wr(16'hFFFF, 8'hFF);
    irq_req_i = 5'h1F; step(); irq_req_i = '0;
    reti_i = 1; step(); reti_i = 0;
    do_rd(16'hFFFF);
    #2 reset = 1;
    #1;
    total++;
    if ({data_o, data_valid_o, interrupt_queued_o,
         halt_wake_o, isr_vector_o} !== 27'd0) begin
      bad++;
      $display("FAIL reset_outputs data=%h v=%b q=%b hw=%b vec=%h exp all 0",
               data_o, data_valid_o, interrupt_queued_o,
               halt_wake_o, isr_vector_o);
    end
    step();
    reset = 0;
    step();
    irq_req_i = 5'h01; step(); irq_req_i = '0;
    do_rd(16'hFF0F);
    total++;
    if (data_o !== 8'hE1 || data_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_if_read got=%h v=%b exp=e1 v=1",
               data_o, data_valid_o);
    end
    step();
    total++;
    if (data_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL valid_one_cycle got=%b exp=0", data_valid_o);
    end
  endtask

  task automatic test_ei_delay();
    do_reset();
    do_wr(16'hFFFF, 8'h04);
    irq_req_i = 5'h04; step(); irq_req_i = '0;
    ei_i = 1; step(); ei_i = 0;
    total++;
    if (interrupt_queued_o !== 1'b0) begin
      bad++;
      $display("FAIL ei_after_ei got=%b exp=0", interrupt_queued_o);
    end
    instr_boundary_i = 1; step(); instr_boundary_i = 0;
    step();
    total++;
    if (interrupt_queued_o !== 1'b0) begin
      bad++;
      $display("FAIL ei_first_boundary got=%b exp=0",
               interrupt_queued_o);
    end
    instr_boundary_i = 1; step(); instr_boundary_i = 0;
    total++;
    if (interrupt_queued_o !== 1'b1) begin
      bad++;
      $display("FAIL ei_second_boundary got=%b exp=1",
               interrupt_queued_o);
    end
  endtask

  task automatic test_priority();
    do_reset();
    do_wr(16'hFFFF, 8'h1F);
    do_wr(16'hFF0F, 8'h14);
    reti_i = 1; step(); reti_i = 0;
    total++;
    if (interrupt_queued_o !== 1'b1) begin
      bad++;
      $display("FAIL prio_queued got=%b exp=1", interrupt_queued_o);
    end
    isr_cmd_i = 1; isr_m_cycle_i = 3'd0;
    #1;
    total++;
    if (interrupt_queued_o !== 1'b0) begin
      bad++;
      $display("FAIL prio_queued_m0 got=%b exp=0",
               interrupt_queued_o);
    end
    for (int m = 0; m < 4; m++) isr_cyc(m);
    total++;
    if (isr_vector_o !== 16'h0050) begin
      bad++;
      $display("FAIL prio_vector got=%h exp=0050", isr_vector_o);
    end
    total++;
    if (interrupt_queued_o !== 1'b0) begin
      bad++;
      $display("FAIL prio_queued_isr got=%b exp=0",
               interrupt_queued_o);
    end
    isr_cyc(4);
    do_rd(16'hFF0F);
    total++;
    if (data_o !== 8'hF0) begin
      bad++;
      $display("FAIL prio_if_ack got=%h exp=f0", data_o);
    end
  endtask

  task automatic test_cancel();
    do_wr(16'hFFFF, 8'h01);
    do_wr(16'hFF0F, 8'h01);
    reti_i = 1; step(); reti_i = 0;
    isr_cyc(0);
    isr_cyc(1);
    addr_i = 16'hFFFF; data_i = 8'h00; wr_en_i = 1;
    isr_cyc(2);
    wr_en_i = 0;
    isr_cyc(3);
    total++;
    if (isr_vector_o !== 16'h0000) begin
      bad++;
      $display("FAIL cancel_vector got=%h exp=0000", isr_vector_o);
    end
    isr_cyc(4);
    do_rd(16'hFF0F);
    total++;
    if (data_o !== 8'hE1) begin
      bad++;
      $display("FAIL cancel_if got=%h exp=e1", data_o);
    end
  endtask

  task automatic test_collision();
    do_reset();
    addr_i = 16'hFF0F; data_i = 8'h00; wr_en_i = 1;
    irq_req_i = 5'h08;
    step();
    wr_en_i = 0; irq_req_i = '0;
    do_rd(16'hFF0F);
    total++;
    if (data_o !== 8'hE8) begin
      bad++;
      $display("FAIL collide_if got=%h exp=e8", data_o);
    end
    do_wr(16'hFFFF, 8'h08);
    ei_i = 1; di_i = 1; step(); ei_i = 0; di_i = 0;
    for (int i = 0; i < 3; i++) begin
      instr_boundary_i = 1; step(); instr_boundary_i = 0;
    end
    total++;
    if (interrupt_queued_o !== 1'b0 || halt_wake_o !== 1'b1) begin
      bad++;
      $display("FAIL collide_di_ei q=%b hw=%b exp q=0 hw=1",
               interrupt_queued_o, halt_wake_o);
    end
    reti_i = 1; di_i = 1; step(); reti_i = 0; di_i = 0;
    total++;
    if (interrupt_queued_o !== 1'b0) begin
      bad++;
      $display("FAIL collide_di_reti got=%b exp=0",
               interrupt_queued_o);
    end
    reti_i = 1; step(); reti_i = 0;
    total++;
    if (interrupt_queued_o !== 1'b1) begin
      bad++;
      $display("FAIL reti_on got=%b exp=1", interrupt_queued_o);
    end
  endtask

  task automatic test_halt_wake();
    do_reset();
    do_wr(16'hFFFF, 8'h10);
    irq_req_i = 5'h10; step(); irq_req_i = '0;
    total++;
    if (halt_wake_o !== 1'b1 || interrupt_queued_o !== 1'b0) begin
      bad++;
      $display("FAIL halt_wake hw=%b q=%b exp hw=1 q=0",
               halt_wake_o, interrupt_queued_o);
    end
  endtask

  // Model: IME is a flag plus a count of boundaries still owed.
  task automatic test_random();
    bit [7:0] m_ie, m_data;
    bit [4:0] m_if;
    bit       m_ime, m_valid;
    int       m_arm;
    bit [15:0] a;
    bit [4:0] pend;
    do_reset();
    m_ie = 0; m_if = 0; m_ime = 0; m_arm = 0;
    m_data = 0; m_valid = 0;
    for (int n = 0; n < 400; n++) begin
      idle();
      case ($urandom % 3)
        0: a = 16'hFF0F;
        1: a = 16'hFFFF;
        default: a = 16'hFF0E;
      endcase
      addr_i  = a;
      data_i  = 8'($urandom);
      wr_en_i = ($urandom % 5 == 0);
      rd_en_i = ($urandom % 3 == 0);
      if ($urandom % 4 == 0) irq_req_i = 5'($urandom);
      ei_i    = ($urandom % 8 == 0);
      di_i    = ($urandom % 16 == 0);
      reti_i  = ($urandom % 20 == 0);
      instr_boundary_i = ($urandom % 3 == 0);

      m_valid = 0;
      if (rd_en_i && a == 16'hFF0F) begin
        m_data = {3'b111, m_if}; m_valid = 1;
      end else if (rd_en_i && a == 16'hFFFF) begin
        m_data = m_ie; m_valid = 1;
      end
      if (wr_en_i && a == 16'hFF0F) m_if = data_i[4:0];
      if (wr_en_i && a == 16'hFFFF) m_ie = data_i;
      m_if = m_if | irq_req_i;
      if (di_i) begin
        m_ime = 0; m_arm = 0;
      end else if (reti_i) begin
        m_ime = 1; m_arm = 0;
      end else if (ei_i && !m_ime && m_arm == 0) begin
        m_arm = 2;
      end else if (m_arm > 0 && instr_boundary_i) begin
        m_arm--;
        if (m_arm == 0) m_ime = 1;
      end
      step();
      pend = m_ie[4:0] & m_if;
      total++;
      if (halt_wake_o !== (pend != 0) ||
          interrupt_queued_o !== (m_ime && pend != 0) ||
          data_valid_o !== m_valid || data_o !== m_data) begin
        bad++;
        $display("FAIL rand_%0d hw=%b q=%b v=%b d=%h exp hw=%b q=%b v=%b d=%h",
                 n, halt_wake_o, interrupt_queued_o,
                 data_valid_o, data_o, pend != 0,
                 m_ime && pend != 0, m_valid, m_data);
      end
    end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    step();
    test_reset();
    test_ei_delay();
    test_priority();
    test_cancel();
    test_collision();
    test_halt_wake();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
# gb_cpu_interrupt_ctrl

Interrupt controller for the GB CPU core. It holds the IE (0xFFFF) and IF (0xFF0F) registers and the IME master enable, including the one-instruction EI delay. It raises `interrupt_queued` to `gb_cpu_scheduler`, and during the scheduler's ISR sequence it resolves the vector and acknowledges the serviced IF bit. It sits beside the scheduler in the CPU top and is accessed through the CPU's internal register bus.

## Interface

Parameters:
- none; vectors, addresses and bit positions come from `gb_cpu_common_pkg`

Ports:
- clk  in  1  CPU clock, one edge per M-cycle
- reset  in  1  asynchronous, active-high
- irq_req_i  in  5  peripheral request pulses, one per source: [0] VBlank, [1] STAT, [2] Timer, [3] Serial, [4] Joypad
- ei_i  in  1  EI executed this cycle
- di_i  in  1  DI executed this cycle
- reti_i  in  1  RETI executed this cycle
- instr_boundary_i  in  1  pulse on the M-cycle in which a new opcode fetch completes
- isr_cmd_i  in  1  scheduler is running the ISR sequence
- isr_m_cycle_i  in  3  current ISR M-cycle, 0..4
- addr_i  in  16  register bus address
- wr_en_i  in  1  register write strobe
- rd_en_i  in  1  register read strobe
- data_i  in  8  write data
- data_o  out  8  read data
- data_valid_o  out  1  read data valid
- interrupt_queued_o  out  1  to the scheduler
- halt_wake_o  out  1  wake request for HALT
- isr_vector_o  out  16  jump target for the ISR sequence

## Operation

Pending interrupts:
- `pend = IE[4:0] & IF[4:0]`

IF register:
- Each `irq_req_i` bit sets the corresponding IF bit.
- A bus write loads IF[4:0] from data_i[4:0].
- A request in the same cycle as a write or an ISR clear wins: the bit ends set.
- Reads return {3'b111, IF[4:0]}.

IE register:
- 8 bits, fully readable and writable.
- Only IE[4:0] take part in `pend`.

Bus access:
- Writes or reads to any address other than 0xFF0F or 0xFFFF are ignored.
- Reads are registered: data_o and data_valid_o update on the edge after rd_en_i.
- data_valid_o is 1 for exactly that one cycle and 0 otherwise.

IME and the EI delay, 3-state FSM:
- States: IME_OFF, IME_ARMING, IME_ON.
- ei_i moves IME_OFF to IME_ARMING.
- In IME_ARMING, the second instr_boundary_i pulse after ei_i moves the FSM to IME_ON. The first pulse is EI's own boundary; IME therefore goes high after the following instruction.
- reti_i moves directly to IME_ON.
- di_i moves any state to IME_OFF and wins over a simultaneous ei_i or reti_i.
- ISR entry (isr_cmd_i=1 and isr_m_cycle_i=0) forces IME_OFF.

Outputs:
- interrupt_queued_o = (state==IME_ON) & |pend.
- halt_wake_o = |pend, independent of IME.

ISR dispatch:
- At isr_m_cycle_i==3, after the scheduler has pushed PC high, pend is resolved by fixed priority, bit 0 highest.
- isr_vector_o latches 0x0040 + 8*index, and that IF bit clears at the same edge.
- If pend==0 at that point (IE overwritten by the push), isr_vector_o latches 0x0000 and no IF bit clears.
- isr_vector_o holds its value until the next resolution.

## Timing

- Reset values: IE=0x00, IF[4:0]=0, IME_OFF, data_o=0x00, data_valid_o=0, isr_vector_o=0x0000, interrupt_queued_o=0, halt_wake_o=0.
- A request pulse at edge N sets IF at edge N. If enabled and IME is on, interrupt_queued_o is high in cycle N+1.
- Write at edge N: the new IE/IF value is visible to interrupt_queued_o and halt_wake_o in cycle N+1.
- Vector latency: isr_vector_o is valid in the cycle after the isr_m_cycle_i==3 edge, i.e. ISR M-cycle 4.
- Reset asserted mid-ISR: everything returns to reset values immediately. isr_cmd_i is ignored until the scheduler restarts.

## Structure

Shared in `gb_cpu_common_pkg`:
- `irq_src_t` enum (VBLANK..JOYPAD)
- `IRQ_VEC_BASE` = 16'h0040
- `ADDR_IF` = 16'hFF0F, `ADDR_IE` = 16'hFFFF
- `ime_state_t` enum

Sub-module: `gb_cpu_irq_prio_enc`, a combinational 5-bit priority encoder with outputs index[2:0] and any.

## Test plan

- **Reset:** assert reset mid-clock. Expected: all outputs 0, and a read of 0xFF0F returns 0xE1 after irq_req_i[0] is pulsed once post-reset.
- **EI delay:** IE=0x04, Timer request pending, ei_i pulsed. Expected: interrupt_queued_o stays 0 through the first instr_boundary_i and goes 1 the cycle after the second.
- **Priority:** IE=0x1F, IF=0x14, IME on, run ISR m-cycles 0-4. Expected: isr_vector_o=0x0050, IF reads 0xF0, interrupt_queued_o=0 from m-cycle 0.
- **Cancelled dispatch:** IME on, IE=0x01, IF=0x01, write IE=0x00 at isr m-cycle 2. Expected: isr_vector_o=0x0000, IF still 0xE1.
- **Collisions:** at the same edge, write IF=0x00 and pulse irq_req_i[3]. Expected: IF reads 0xE8. Then DI together with EI. Expected: IME stays off.
- **HALT wake:** IME off, IE=0x10, Joypad request. Expected: halt_wake_o=1, interrupt_queued_o=0.
